netlist_stim_capture: RTL and testbench

NETLIST_STIM_CAPTURE -- requirements
Module: netlist_stim_capture

---
 rtl/netlist_stim_pkg.sv | 20 ++
 rtl/netlist_misr.sv | 31 +++
 rtl/netlist_stim_capture.sv | 120 ++++++++++++
 tb/tb_netlist_stim_capture.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/netlist_stim_pkg.sv
// Shared definitions for the netlist stimulus/capture block: default widths,
// signature feedback taps and the sequencing state encoding.
package netlist_stim_pkg;

  localparam int VEC_W_DEF = 13;
  localparam int SIG_W_DEF = 16;
  localparam int CNT_W_DEF = 16;

  // Feedback taps of the response signature: bits 15, 13, 12 and 10.
  localparam logic [15:0] MISR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/netlist_misr.sv
// Serial-input signature register. Shifts left by one on enable, feeding the
// XOR of the tapped bits and the serial input into bit 0.
module netlist_misr
  import netlist_stim_pkg::*;
#(
  parameter int SIG_W = SIG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  localparam logic [SIG_W-1:0] TAPS = SIG_W'(MISR_TAPS);

  logic fb;

  assign fb = (^(sig & TAPS)) ^ din;

  // Reset and clear win over a shift in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sig <= '0;
    end else if (enable) begin
      sig <= {sig[SIG_W-2:0], fb};
    end
  end

endmodule

// File: rtl/netlist_stim_capture.sv
// Drives vectors into a combinational netlist, lets them settle for a fixed
// number of cycles, then folds the netlist output into a running signature.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | after reset, waiting for start
// ACCEPT | vec_ready high, waiting for the next upstream vector
// SETTLE | n_in held, counting down the settle time
// SAMPLE | n_out captured into the signature on this edge
// DONE   | run complete, results held until start or rst
module netlist_stim_capture
  import netlist_stim_pkg::*;
#(
  parameter int VEC_W      = VEC_W_DEF,
  parameter int SETTLE_CYC = 2,
  parameter int SIG_W      = SIG_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             vec_valid,
  input  logic [VEC_W-1:0] vec_data,
  output logic             vec_ready,
  output logic [VEC_W-1:0] n_in,
  input  logic             n_out,
  output logic [SIG_W-1:0] sig,
  output logic [CNT_W-1:0] vec_count,
  output logic             busy,
  output logic             done
);

  // Settle counter starts one below SETTLE_CYC so SETTLE lasts SETTLE_CYC cycles.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  state_t           state;
  logic [3:0]       settle_cnt;
  logic [CNT_W-1:0] num_lat;
  logic [CNT_W-1:0] cnt_next;
  logic             start_ok;
  logic             misr_en;

  assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign misr_en   = (state == ST_SAMPLE);
  assign cnt_next  = vec_count + CNT_W'(1);
  assign vec_ready = (state == ST_ACCEPT);

  netlist_misr #(
    .SIG_W(SIG_W)
  ) u_misr (
    .clk   (clk),
    .rst   (rst),
    .clear (start_ok),
    .enable(misr_en),
    .din   (n_out),
    .sig   (sig)
  );

  // Sequencing FSM with vector register, counters and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      n_in       <= '0;
      vec_count  <= '0;
      settle_cnt <= '0;
      num_lat    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            num_lat   <= num_vec;
            vec_count <= '0;
            if (num_vec == '0) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= ST_ACCEPT;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        ST_ACCEPT: begin
          if (vec_valid) begin
            n_in       <= vec_data;
            settle_cnt <= SETTLE_LOAD;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == 4'd0) begin
            state <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        ST_SAMPLE: begin
          vec_count <= cnt_next;
          if (cnt_next == num_lat) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= ST_ACCEPT;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_netlist_stim_capture.sv
// Scoreboard bench: the driver predicts each accepted vector's signature and
// sample time, the monitor checks them when vec_count advances.
module tb_netlist_stim_capture;

  localparam int VEC_W      = 13;
  localparam int SIG_W      = 16;
  localparam int CNT_W      = 16;
  localparam int SETTLE_CYC = 2;
  localparam int LAT        = SETTLE_CYC + 2;
  localparam logic [12:0] NET_MASK = 13'h1A5B;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_vec = '0;
  logic             vec_valid = 1'b0;
  logic [VEC_W-1:0] vec_data = '0;
  logic             vec_ready;
  logic [VEC_W-1:0] n_in;
  logic             n_out;
  logic [SIG_W-1:0] sig;
  logic [CNT_W-1:0] vec_count;
  logic             busy;
  logic             done;

  typedef struct {
    logic [15:0] sig;
    int          cnt;
    int          acc;
    logic [12:0] vec;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   n_mode = 0;
  int   ncyc = 0;

  netlist_stim_capture #(
    .VEC_W(VEC_W), .SETTLE_CYC(SETTLE_CYC), .SIG_W(SIG_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
    .vec_valid(vec_valid), .vec_data(vec_data), .vec_ready(vec_ready),
    .n_in(n_in), .n_out(n_out), .sig(sig), .vec_count(vec_count),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  function automatic logic net_out(input int mode, input logic [12:0] v);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return ^(v & NET_MASK);
  endfunction

  // Netlist under stimulus: constant 0, constant 1, or a parity tree.
  assign n_out = net_out(n_mode, n_in);

  function automatic logic [15:0] sig_step(input logic [15:0] s, input logic b);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10] ^ b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_n_in"}, 32'(n_in), 0);
    chk({tag, "_sig"}, 32'(sig), 0);
    chk({tag, "_count"}, 32'(vec_count), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_ready"}, 32'(vec_ready), 0);
  endtask

  // One run: start, feed n vectors, wait for done (or reset mid-run at rst_at).
  task automatic run(input int n, input int mode, input int vprob, input int hold,
                     input bit inject, input int rst_at, input int fixed);
    logic [15:0] msig = '0;
    int n_acc = 0;
    int acc_cyc = 0;
    int next_rdy;
    int guard;
    bit ready_exp;
    n_mode = mode;
    @(negedge clk);
    start = 1'b1;
    num_vec = CNT_W'(n);
    next_rdy = ncyc + 1;
    @(negedge clk);
    start = 1'b0;
    num_vec = CNT_W'($urandom);
    if (n == 0) begin
      chk("zero_done", 32'(done), 1);
      chk("zero_busy", 32'(busy), 0);
      chk("zero_sig", 32'(sig), 0);
      chk("zero_count", 32'(vec_count), 0);
      repeat (3) begin
        chk("zero_ready", 32'(vec_ready), 0);
        vec_valid = 1'b1;
        @(negedge clk);
      end
      chk("zero_done_hold", 32'(done), 1);
      vec_valid = 1'b0;
      return;
    end
    guard = 0;
    while (n_acc < n && guard < 2000) begin
      ready_exp = (ncyc >= next_rdy);
      chk("vec_ready", 32'(vec_ready), 32'(ready_exp));
      chk("busy_run", 32'(busy), 1);
      if (rst_at != 0 && n_acc == rst_at && ncyc == acc_cyc + 1) begin
        rst = 1'b1;
        start = 1'b1;
        vec_valid = 1'b1;
        num_vec = 16'd5;
        sbq.delete();
        @(negedge clk);
        chk_reset_outputs("midrst");
        start = 1'b0;
        vec_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_outputs("midrst_hold");
        return;
      end
      start = inject && (n_acc == 1) && (ncyc == acc_cyc + 1);
      if (start) num_vec = 16'd7;
      vec_valid = ($urandom_range(99) < vprob) && (hold == 0);
      vec_data = (fixed >= 0) ? 13'(fixed) : 13'($urandom);
      if (ready_exp && hold > 0) hold--;
      if (ready_exp && vec_valid) begin
        msig = sig_step(msig, net_out(mode, vec_data));
        n_acc++;
        acc_cyc = ncyc;
        next_rdy = ncyc + LAT;
        sbq.push_back('{msig, n_acc, ncyc, vec_data});
      end
      @(negedge clk);
      guard++;
    end
    chk("accept_budget", 32'(n_acc), 32'(n));
    start = 1'b0;
    guard = 0;
    while (!done && guard < 20) begin
      chk("ready_low_tail", 32'(vec_ready), 0);
      vec_valid = 1'($urandom_range(1));
      @(negedge clk);
      guard++;
    end
    chk("done_reached", 32'(done), 1);
    chk("final_count", 32'(vec_count), 32'(n));
    chk("final_sig", 32'(sig), 32'(msig));
    chk("final_busy", 32'(busy), 0);
    chk("final_ready", 32'(vec_ready), 0);
    vec_valid = 1'b0;
  endtask

  // Monitor: pops an expectation each time vec_count advances; tracks n_in.
  initial begin
    exp_t        e;
    logic [12:0] mon_last;
    logic [12:0] exp_nin;
    int          prev_cnt;
    mon_last = '0;
    prev_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_last = '0;
        prev_cnt = 0;
      end else begin
        if (int'(vec_count) != prev_cnt && vec_count != '0) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_sample: got count %0d required no sample", vec_count);
          end else begin
            e = sbq.pop_front();
            chk("sample_sig", 32'(sig), 32'(e.sig));
            chk("sample_count", 32'(vec_count), 32'(e.cnt));
            chk("sample_latency", 32'(ncyc - e.acc), 32'(LAT));
            mon_last = e.vec;
          end
        end
        exp_nin = (sbq.size() > 0 && sbq[0].acc < ncyc) ? sbq[0].vec : mon_last;
        chk("n_in", 32'(n_in), 32'(exp_nin));
        prev_cnt = int'(vec_count);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    run(0, 1, 100, 0, 1'b0, 0, -1);
    run(2, 1, 100, 0, 1'b0, 0, -1);
    chk("ones_sig", 32'(sig), 32'h0003);
    run(1, 0, 100, 0, 1'b0, 0, 13'h1ABC);
    chk("zeros_sig", 32'(sig), 32'h0000);
    chk("fixed_n_in", 32'(n_in), 32'h1ABC);
    run(3, 2, 100, 5, 1'b0, 0, -1);
    run(10, 2, 60, 0, 1'b0, 3, -1);
    run(1, 2, 100, 0, 1'b0, 0, -1);
    run(4, 2, 100, 0, 1'b1, 0, -1);
    chk("inject_count", 32'(vec_count), 4);
    for (int i = 0; i < 6; i++) begin
      run(int'($urandom_range(8, 1)), 2, int'($urandom_range(100, 40)), 0, 1'b0, 0, -1);
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
